// File: rtl/fib_seq_engine.sv
// Fibonacci sequencing stage: on an accepted start request it streams
// F(0)..F(n) mod 2^WIDTH over a valid/ready handshake, tagging each beat
// with its index, a last marker and a sticky overflow flag.
module fib_seq_engine #(
  parameter int WIDTH = 8,
  parameter int NBITS = 5
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic [NBITS-1:0] n,
  output logic             busy,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [NBITS-1:0] o_idx,
  output logic             o_last,
  output logic             o_ovf
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [NBITS-1:0]   r_k;
  logic [NBITS-1:0]   r_n_lat;
  logic               r_a_wrap;
  logic               r_b_wrap;
  logic               r_last;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_a_nxt;
  logic [WIDTH-1:0]   w_b_nxt;
  logic [NBITS-1:0]   w_k_nxt;
  logic [NBITS-1:0]   w_n_lat_nxt;
  logic               w_a_wrap_nxt;
  logic               w_b_wrap_nxt;
  logic               w_last_nxt;

  // One extra bit on the sum keeps the carry out of a+b for the wrap flag.
  logic [WIDTH:0]     w_sum;
  logic [NBITS-1:0]   w_k_inc;
  logic               w_fire;

  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_k_inc = r_k + 1'b1;
  assign w_fire  = (r_state == S_EMIT) && o_ready;

  // Next-state and next-datapath decode for the IDLE/EMIT sequencer.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves
    // one unassigned; that is what keeps this block from inferring latches.
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_k_nxt      = r_k;
    w_n_lat_nxt  = r_n_lat;
    w_a_wrap_nxt = r_a_wrap;
    w_b_wrap_nxt = r_b_wrap;
    w_last_nxt   = r_last;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_EMIT;
          w_n_lat_nxt  = n;
          w_a_nxt      = '0;
          w_b_nxt      = WIDTH'(1);
          w_k_nxt      = '0;
          w_a_wrap_nxt = 1'b0;
          w_b_wrap_nxt = 1'b0;
          w_last_nxt   = (n == '0);
        end
      end

      S_EMIT: begin
        if (w_fire) begin
          if (r_k == r_n_lat) begin
            // Final beat taken: park the datapath in its reset values so
            // all outputs read zero while idle.
            w_state_nxt  = S_IDLE;
            w_a_nxt      = '0;
            w_b_nxt      = WIDTH'(1);
            w_k_nxt      = '0;
            w_a_wrap_nxt = 1'b0;
            w_b_wrap_nxt = 1'b0;
            w_last_nxt   = 1'b0;
          end else begin
            w_a_nxt      = r_b;
            w_b_nxt      = w_sum[WIDTH-1:0];
            w_k_nxt      = w_k_inc;
            w_a_wrap_nxt = r_b_wrap;
            // Sticky: once any earlier term wrapped, every later term's
            // true value is also out of range.
            w_b_wrap_nxt = w_sum[WIDTH] | r_a_wrap | r_b_wrap;
            w_last_nxt   = (w_k_inc == r_n_lat);
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; CLR overrides any start or handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (CLR) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= WIDTH'(1);
      r_k      <= '0;
      r_n_lat  <= '0;
      r_a_wrap <= 1'b0;
      r_b_wrap <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_k      <= w_k_nxt;
      r_n_lat  <= w_n_lat_nxt;
      r_a_wrap <= w_a_wrap_nxt;
      r_b_wrap <= w_b_wrap_nxt;
      r_last   <= w_last_nxt;
    end
  end

  // Outputs come straight from flops, so they are glitch-free and hold
  // steady across stalled cycles.
  assign busy    = (r_state == S_EMIT);
  assign o_valid = (r_state == S_EMIT);
  assign o_data  = r_a;
  assign o_idx   = r_k;
  assign o_last  = r_last;
  assign o_ovf   = r_a_wrap;

endmodule
